vc_input_port: RTL and testbench

- Parametrised successor to the single-channel status buffer.
- Full router input port: VC_NUM virtual channels, each with its own flit FIFO and per-VC state machine (IDLE -> VC_ALLOC -> SWITCH).
- Issues VC-allocation and switch-allocation requests, and rewrites the outgoing flit's VC field.
- Sits between the upstream link and the router's VC/switch allocators.

---
 rtl/vc_input_port_pkg.sv | 19 +
 rtl/vc_input_port_if.sv | 25 ++
 rtl/vc_input_port_fifo.sv | 41 ++++
 rtl/vc_input_port.sv | 62 ++++++
 tb/tb_vc_input_port.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/vc_input_port_pkg.sv
// params_noc: shared NoC types for the VC input port (flit format, ports, per-VC states)
package params_noc;
  localparam int VC_NUM_DEF = 2;
  localparam int VC_Size = (VC_NUM_DEF > 1) ? $clog2(VC_NUM_DEF) : 1;
  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_type_t;
  typedef enum logic [2:0] {LOCAL, NORTH, EAST, SOUTH, WEST} inout_Port;
  typedef struct packed {
    flit_type_t flit_type;
    logic [VC_Size-1:0] vc;
    logic [15:0] data;
  } flit_Data_withvc;
  typedef enum logic [1:0] {IDLE, VC_ALLOC, SWITCH} vc_state_t;
  function automatic logic is_head(flit_type_t t);
    return t == HEAD || t == HEADTAIL;
  endfunction
  function automatic logic is_tail(flit_type_t t);
    return t == TAIL || t == HEADTAIL;
  endfunction
endpackage

// File: rtl/vc_input_port_if.sv
// vc_input_port_if: link/allocator bundle of one router input port
//   slave  (the port): takes flit_i, write_i, read_i, route_i, vc_new_i, vc_valid_i;
//                      drives flit_o, empty_o, full_o, on_off_o, vc_req_o,
//                      switch_req_o, port_o, downstream_vc_o, err_o
//   master (link + allocators): the reverse directions
interface vc_input_port_if import params_noc::*; #(parameter int VC_NUM = VC_NUM_DEF);
  flit_Data_withvc flit_i;
  logic write_i;
  logic [VC_NUM-1:0] read_i;
  inout_Port route_i [VC_NUM];
  logic [VC_Size-1:0] vc_new_i [VC_NUM];
  logic [VC_NUM-1:0] vc_valid_i;
  flit_Data_withvc flit_o [VC_NUM];
  logic [VC_NUM-1:0] empty_o, full_o, on_off_o, vc_req_o, switch_req_o, err_o;
  inout_Port port_o [VC_NUM];
  logic [VC_Size-1:0] downstream_vc_o [VC_NUM];
  modport slave (
    input flit_i, write_i, read_i, route_i, vc_new_i, vc_valid_i,
    output flit_o, empty_o, full_o, on_off_o, vc_req_o, switch_req_o, port_o, downstream_vc_o, err_o
  );
  modport master (
    output flit_i, write_i, read_i, route_i, vc_new_i, vc_valid_i,
    input flit_o, empty_o, full_o, on_off_o, vc_req_o, switch_req_o, port_o, downstream_vc_o, err_o
  );
endinterface

// File: rtl/vc_input_port_fifo.sv
// vc_fifo: single-VC circular flit FIFO with empty/full/on_off flags
//   clk, rst_n (sync, active low); wr/din push; rd pop; dout = head (combinational)
//   a push to a full FIFO is taken only together with an accepted pop; a pop of an empty FIFO is dropped
module vc_fifo import params_noc::*; #(
  parameter int BUFFER_SIZE = 8,
  parameter int OFF_THRESHOLD = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr,
  input  logic rd,
  input  flit_Data_withvc din,
  output flit_Data_withvc dout,
  output logic empty,
  output logic full,
  output logic on_off
);
  localparam int AW = $clog2(BUFFER_SIZE);
  flit_Data_withvc mem [BUFFER_SIZE];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_rd, do_wr;
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(BUFFER_SIZE);
  assign on_off = cnt < (AW+1)'(OFF_THRESHOLD);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_wr) mem[wp] <= din;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(do_wr);
      rp <= rp + AW'(do_rd);
      cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
endmodule

// File: rtl/vc_input_port.sv
// vc_input_port: router input port with VC_NUM virtual channels, each a FIFO plus IDLE->VC_ALLOC->SWITCH FSM
//   clk, rst_n (sync, active low); bus (vc_input_port_if.slave) carries the link and allocator signals
//   VC_INPUT_PORT_ERR_CHECK_EN: when defined, illegal events set sticky err_o and stray
//   BODY/TAIL head flits are dropped; otherwise err_o=0 and such flits are treated as heads
module vc_input_port import params_noc::*; #(
  parameter int VC_NUM = VC_NUM_DEF,
  parameter int BUFFER_SIZE = 8,
  parameter int OFF_THRESHOLD = 6
) (
  input logic clk,
  input logic rst_n,
  vc_input_port_if.slave bus
);
  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    flit_Data_withvc head;
    vc_state_t st, st_n;
    inout_Port port;
    logic [VC_Size-1:0] dvc;
    logic wr, rd, pop, drop, empty, full, on_off;
    assign wr = bus.write_i && bus.flit_i.vc == VC_Size'(v);
    assign rd = (bus.read_i[v] && st == SWITCH) || drop;
    assign pop = rd && !empty;
    vc_fifo #(.BUFFER_SIZE(BUFFER_SIZE), .OFF_THRESHOLD(OFF_THRESHOLD)) u_fifo (
      .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .din(bus.flit_i),
      .dout(head), .empty(empty), .full(full), .on_off(on_off)
    );
    always_comb
      st_n = (st == IDLE) ? ((!empty && !drop) ? VC_ALLOC : IDLE)
           : (st == VC_ALLOC) ? (bus.vc_valid_i[v] ? SWITCH : VC_ALLOC)
           : ((pop && is_tail(head.flit_type)) ? IDLE : SWITCH);
    always_ff @(posedge clk)
      if (!rst_n) begin
        st <= IDLE;
        port <= LOCAL;
        dvc <= '0;
      end else begin
        st <= st_n;
        if (st == IDLE && st_n == VC_ALLOC) port <= bus.route_i[v];
        if (st == VC_ALLOC && bus.vc_valid_i[v]) dvc <= bus.vc_new_i[v];
      end
`ifdef VC_INPUT_PORT_ERR_CHECK_EN
    logic err;
    assign drop = st == IDLE && !empty && !is_head(head.flit_type);
    always_ff @(posedge clk)
      if (!rst_n) err <= 1'b0;
      else err <= err | (wr && full && !pop) | (bus.read_i[v] && (empty || st != SWITCH)) | drop;
    assign bus.err_o[v] = err;
`else
    assign drop = 1'b0;
    assign bus.err_o[v] = 1'b0;
`endif
    assign bus.flit_o[v] = (st == SWITCH)
      ? flit_Data_withvc'{flit_type: head.flit_type, vc: dvc, data: head.data} : head;
    assign bus.empty_o[v] = empty;
    assign bus.full_o[v] = full;
    assign bus.on_off_o[v] = on_off;
    assign bus.vc_req_o[v] = st == VC_ALLOC;
    assign bus.switch_req_o[v] = st == SWITCH && !empty;
    assign bus.port_o[v] = port;
    assign bus.downstream_vc_o[v] = dvc;
  end
endmodule

// File: tb/tb_vc_input_port.sv
// tb_vc_input_port: directed self-checking bench for vc_input_port
module tb_vc_input_port;
  import params_noc::*;
`ifdef VC_INPUT_PORT_ERR_CHECK_EN
  localparam logic E = 1'b1;
`else
  localparam logic E = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_err = 0;
  vc_input_port_if #(.VC_NUM(2)) bus ();
  vc_input_port #(.VC_NUM(2), .BUFFER_SIZE(8), .OFF_THRESHOLD(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input flit_type_t t, input int vc, input logic [15:0] d);
    bus.flit_i = '{flit_type: t, vc: VC_Size'(vc), data: d};
    bus.write_i = 1'b1;
    tick();
    bus.write_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"}, bus.empty_o, 2'b11);
    chk({tag, "_full"}, bus.full_o, 2'b00);
    chk({tag, "_onoff"}, bus.on_off_o, 2'b11);
    chk({tag, "_err"}, bus.err_o, 2'b00);
    chk({tag, "_vcreq"}, bus.vc_req_o, 2'b00);
    chk({tag, "_swreq"}, bus.switch_req_o, 2'b00);
    chk({tag, "_port0"}, bus.port_o[0], LOCAL);
    chk({tag, "_port1"}, bus.port_o[1], LOCAL);
    chk({tag, "_dvc0"}, bus.downstream_vc_o[0], 0);
    chk({tag, "_dvc1"}, bus.downstream_vc_o[1], 0);
  endtask

  typedef struct {int vc; logic [15:0] d;} pop_t;
  pop_t pops [6];

  initial begin
    rst_n = 1'b0;
    bus.write_i = 1'b0;
    bus.read_i = '0;
    bus.vc_valid_i = '0;
    bus.flit_i = '0;
    bus.route_i[0] = LOCAL;
    bus.route_i[1] = LOCAL;
    bus.vc_new_i[0] = '0;
    bus.vc_new_i[1] = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_reset_state("rst");

    // single HEADTAIL on VC1
    bus.route_i[1] = EAST;
    wr(HEADTAIL, 1, 16'h00a5);
    chk("ht_notempty", bus.empty_o[1], 1'b0);
    chk("ht_req_n1", bus.vc_req_o, 2'b00);
    tick();
    chk("ht_req_n2", bus.vc_req_o, 2'b10);
    chk("ht_port", bus.port_o[1], EAST);
    bus.vc_valid_i[1] = 1'b1;
    bus.vc_new_i[1] = 1'b0;
    tick();
    bus.vc_valid_i = '0;
    chk("ht_swreq", bus.switch_req_o, 2'b10);
    chk("ht_vcreq_off", bus.vc_req_o, 2'b00);
    chk("ht_flit_vc", bus.flit_o[1].vc, 0);
    chk("ht_flit_data", bus.flit_o[1].data, 16'h00a5);
    bus.read_i[1] = 1'b1;
    tick();
    bus.read_i = '0;
    chk("ht_empty", bus.empty_o[1], 1'b1);
    chk("ht_swreq_off", bus.switch_req_o, 2'b00);
    tick();
    chk("ht_idle", bus.vc_req_o, 2'b00);
    chk("ht_err", bus.err_o, 2'b00);

    // interleaved packets: 4 flits on VC0, 2 flits on VC1
    bus.route_i[0] = NORTH;
    bus.route_i[1] = WEST;
    wr(HEAD, 0, 16'h0010);
    wr(HEAD, 1, 16'h0020);
    wr(BODY, 0, 16'h0011);
    wr(TAIL, 1, 16'h0021);
    wr(BODY, 0, 16'h0012);
    wr(TAIL, 0, 16'h0013);
    chk("il_vcreq", bus.vc_req_o, 2'b11);
    chk("il_port0", bus.port_o[0], NORTH);
    chk("il_port1", bus.port_o[1], WEST);
    bus.vc_valid_i = 2'b11;
    bus.vc_new_i[0] = 1'b1;
    bus.vc_new_i[1] = 1'b0;
    tick();
    bus.vc_valid_i = '0;
    chk("il_swreq", bus.switch_req_o, 2'b11);
    chk("il_vc0", bus.flit_o[0].vc, 1);
    chk("il_vc1", bus.flit_o[1].vc, 0);
    pops = '{'{0, 16'h0010}, '{1, 16'h0020}, '{0, 16'h0011}, '{1, 16'h0021}, '{0, 16'h0012}, '{0, 16'h0013}};
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("il_pop%0d", i), bus.flit_o[pops[i].vc].data, pops[i].d);
      bus.read_i[pops[i].vc] = 1'b1;
      tick();
      bus.read_i = '0;
      if (i == 3) chk("il_vc1_idle", {bus.vc_req_o[1], bus.switch_req_o[1], bus.empty_o[1]}, 3'b001);
    end
    chk("il_done_req", {bus.vc_req_o, bus.switch_req_o}, 4'b0000);
    chk("il_done_empty", bus.empty_o, 2'b11);
    chk("il_err", bus.err_o, 2'b00);

    // fill VC0 to full, then read+write while full, then overflow
    for (int i = 0; i < 8; i++) begin
      wr(i == 0 ? HEAD : BODY, 0, 16'h0030 + 16'(i));
      if (i == 4) chk("fill5_on", bus.on_off_o[0], 1'b1);
      if (i == 5) chk("fill6_off", bus.on_off_o[0], 1'b0);
      if (i == 6) chk("fill7_notfull", bus.full_o[0], 1'b0);
    end
    chk("fill8_full", bus.full_o[0], 1'b1);
    bus.vc_valid_i[0] = 1'b1;
    bus.vc_new_i[0] = 1'b1;
    tick();
    bus.vc_valid_i = '0;
    chk("fill_swreq", bus.switch_req_o[0], 1'b1);
    bus.read_i[0] = 1'b1;
    wr(BODY, 0, 16'h0038);
    bus.read_i = '0;
    chk("rw_full", bus.full_o[0], 1'b1);
    chk("rw_err", bus.err_o, 2'b00);
    chk("rw_head", bus.flit_o[0].data, 16'h0031);
    wr(BODY, 0, 16'h0039);
    chk("ovf_err", bus.err_o, {1'b0, E});
    chk("ovf_full", bus.full_o[0], 1'b1);
    chk("ovf_head", bus.flit_o[0].data, 16'h0031);
    do_reset();
    chk("rst2_empty", bus.empty_o, 2'b11);
    chk("rst2_err", bus.err_o, 2'b00);

    // read while VC1 in VC_ALLOC
    bus.route_i[1] = EAST;
    wr(HEAD, 1, 16'h0040);
    tick();
    bus.read_i[1] = 1'b1;
    tick();
    bus.read_i = '0;
    chk("rdva_err", bus.err_o, {E, 1'b0});
    chk("rdva_notempty", bus.empty_o[1], 1'b0);
    chk("rdva_vcreq", bus.vc_req_o[1], 1'b1);
    do_reset();

    // stray BODY at the head of idle VC0
    wr(BODY, 0, 16'h0055);
    chk("body_queued", bus.empty_o[0], 1'b0);
    tick();
`ifdef VC_INPUT_PORT_ERR_CHECK_EN
    chk("body_dropped", bus.empty_o[0], 1'b1);
    chk("body_vcreq", bus.vc_req_o, 2'b00);
`else
    chk("body_kept", bus.empty_o[0], 1'b0);
    chk("body_vcreq", bus.vc_req_o, 2'b01);
`endif
    chk("body_err", bus.err_o, {1'b0, E});
    do_reset();

    // reset mid-packet with 5 flits queued
    bus.route_i[0] = SOUTH;
    wr(HEAD, 0, 16'h0060);
    for (int i = 1; i < 5; i++) wr(BODY, 0, 16'h0060 + 16'(i));
    chk("mid_port", bus.port_o[0], SOUTH);
    bus.vc_valid_i[0] = 1'b1;
    bus.vc_new_i[0] = 1'b1;
    tick();
    bus.vc_valid_i = '0;
    chk("mid_dvc", bus.downstream_vc_o[0], 1);
    chk("mid_swreq", bus.switch_req_o, 2'b01);
    do_reset();
    chk_reset_state("mid_rst");
    wr(HEADTAIL, 0, 16'h0066);
    tick();
    chk("post_vcreq", bus.vc_req_o, 2'b01);
    chk("post_port", bus.port_o[0], SOUTH);
    chk("post_data", bus.flit_o[0].data, 16'h0066);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
